// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
//   On-chip trace recorder for the 5-stage pipeline. Captures timestamped
//   write-back events into a circular buffer while in RUN. Capture freezes
//   on halt, timeout, full (non-wrapping) or an external stop. Entries are
//   drained oldest-first through a request/valid port while in DONE.
// Ports:
//   clk, reset            clock, async active-high reset
//   arm, stop             start capture (IDLE/DONE), external stop (RUN)
//   mode_all, wrap_en     capture mode and wrap policy, latched at arm
//   wb_we/wb_rd/wb_data   write-back tap
//   pc, stall, halt       pipeline status taps
//   rd_req                pop the oldest entry (DONE only)
//   rd_valid, rd_*        one-cycle readout pulse and entry fields
//   state, count          FSM state (IDLE=00, RUN=01, DONE=10), entries held
//   overflow, stop_cause  entry lost to wrap, reason for the last stop
module pipeline_trace_buffer #(
  parameter int DATA_W  = 16,
  parameter int PC_W    = 16,
  parameter int RIDX_W  = 3,
  parameter int DEPTH   = 16,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     mode_all,
  input  logic                     wrap_en,
  input  logic                     wb_we,
  input  logic [RIDX_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [PC_W-1:0]          pc,
  input  logic                     stall,
  input  logic                     halt,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [PC_W-1:0]          rd_pc,
  output logic [RIDX_W-1:0]        rd_reg,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_stall,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [1:0]               stop_cause
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CYC_W + PC_W + RIDX_W + DATA_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);
  localparam logic [CYC_W-1:0] TO_LAST = CYC_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  typedef enum logic [1:0] {
    CAUSE_EXT     = 2'b00,
    CAUSE_HALT    = 2'b01,
    CAUSE_TIMEOUT = 2'b10,
    CAUSE_FULL    = 2'b11
  } cause_t;

  state_t            st;
  cause_t            cause;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CYC_W-1:0]  cyc;
  logic              mode_q;
  logic              wrap_q;
  logic [EW-1:0]     mem [DEPTH];

  logic capture;
  logic is_full;
  logic fill_stop;
  logic timeout_hit;

  assign state      = st;
  assign stop_cause = cause;

  always_comb begin
    capture     = (st == RUN) && (mode_q || wb_we);
    is_full     = (count == FULL_CNT);
    // Non-wrapping capture stops on the write that fills the last slot.
    fill_stop   = capture && !wrap_q && (count == LAST_CNT);
    timeout_hit = (TIMEOUT != 0) && (cyc == TO_LAST);
  end

  // Buffer storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr] <= {cyc, pc, wb_rd, wb_data, stall};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      cause    <= CAUSE_EXT;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cyc      <= '0;
      mode_q   <= 1'b0;
      wrap_q   <= 1'b0;
      rd_valid <= 1'b0;
      rd_cycle <= '0;
      rd_pc    <= '0;
      rd_reg   <= '0;
      rd_data  <= '0;
      rd_stall <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      // arm outranks rd_req in DONE, so it is handled ahead of the state case.
      if (arm && st != RUN) begin
        st       <= RUN;
        cause    <= CAUSE_EXT;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
        cyc      <= '0;
        mode_q   <= mode_all;
        wrap_q   <= wrap_en;
      end else begin
        case (st)
          RUN: begin
            if (capture) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (is_full) begin
                // Overwrite of the oldest entry drags the read pointer along.
                rd_ptr   <= rd_ptr + 1'b1;
                overflow <= 1'b1;
              end else begin
                count <= count + 1'b1;
              end
            end
            if (cyc != '1) begin
              cyc <= cyc + 1'b1;
            end
            if (halt) begin
              st    <= DONE;
              cause <= CAUSE_HALT;
            end else if (timeout_hit) begin
              st    <= DONE;
              cause <= CAUSE_TIMEOUT;
            end else if (fill_stop) begin
              st    <= DONE;
              cause <= CAUSE_FULL;
            end else if (stop) begin
              st    <= DONE;
              cause <= CAUSE_EXT;
            end
          end
          DONE: begin
            if (rd_req && count != '0) begin
              rd_valid <= 1'b1;
              {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} <= mem[rd_ptr];
              rd_ptr   <= rd_ptr + 1'b1;
              count    <= count - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// tb_pipeline_trace_buffer
//   Self-checking bench for pipeline_trace_buffer. A queue-based model of the
//   trace buffer follows every clock edge; directed scenarios also check the
//   documented outcomes as constants.
module tb_pipeline_trace_buffer;

  localparam int DATA_W  = 16;
  localparam int PC_W    = 16;
  localparam int RIDX_W  = 3;
  localparam int DEPTH   = 16;
  localparam int CYC_W   = 16;
  localparam int TIMEOUT = 200;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              arm, stop, mode_all, wrap_en, wb_we, stall, halt, rd_req;
  logic [RIDX_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [PC_W-1:0]   pc;
  logic              rd_valid, rd_stall, overflow;
  logic [CYC_W-1:0]  rd_cycle;
  logic [PC_W-1:0]   rd_pc;
  logic [RIDX_W-1:0] rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        state, stop_cause;
  logic [CW-1:0]     count;

  int n_vec = 0;
  int n_err = 0;

  pipeline_trace_buffer #(
    .DATA_W(DATA_W), .PC_W(PC_W), .RIDX_W(RIDX_W),
    .DEPTH(DEPTH), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .stop(stop),
    .mode_all(mode_all), .wrap_en(wrap_en), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .pc(pc), .stall(stall), .halt(halt), .rd_req(rd_req),
    .rd_valid(rd_valid), .rd_cycle(rd_cycle), .rd_pc(rd_pc), .rd_reg(rd_reg),
    .rd_data(rd_data), .rd_stall(rd_stall), .state(state), .count(count),
    .overflow(overflow), .stop_cause(stop_cause)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [CYC_W-1:0]  cyc;
    logic [PC_W-1:0]   pc;
    logic [RIDX_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              stall;
  } entry_t;

  entry_t      q[$];
  logic [1:0]  m_state;
  logic [1:0]  m_cause;
  int unsigned m_cyc;
  bit          m_mode, m_wrap, m_ovf, m_rv;
  entry_t      m_rd;

  task automatic model_reset();
    q.delete();
    m_state = 2'b00; m_cause = 2'b00; m_cyc = 0;
    m_mode = 0; m_wrap = 0; m_ovf = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic model_arm();
    q.delete();
    m_state = 2'b01; m_cause = 2'b00; m_cyc = 0; m_ovf = 0;
    m_mode = mode_all; m_wrap = wrap_en;
  endtask

  // Applies the current inputs as they are seen at the coming rising edge.
  task automatic model_step();
    entry_t e;
    bit cap, filled, to;
    m_rv = 0;
    if (reset) begin
      model_reset();
    end else if (m_state == 2'b00) begin
      if (arm) model_arm();
    end else if (m_state == 2'b01) begin
      cap = m_mode || wb_we;
      filled = 0;
      if (cap) begin
        e.cyc = CYC_W'(m_cyc); e.pc = pc; e.rd = wb_rd; e.data = wb_data; e.stall = stall;
        q.push_back(e);
        if (q.size() > DEPTH) begin
          e = q.pop_front();
          m_ovf = 1;
        end
        filled = !m_wrap && (q.size() == DEPTH);
      end
      to = (TIMEOUT != 0) && (m_cyc == TIMEOUT - 1);
      if (halt)        begin m_state = 2'b10; m_cause = 2'b01; end
      else if (to)     begin m_state = 2'b10; m_cause = 2'b10; end
      else if (filled) begin m_state = 2'b10; m_cause = 2'b11; end
      else if (stop)   begin m_state = 2'b10; m_cause = 2'b00; end
      if (m_cyc < (2 ** CYC_W) - 1) m_cyc++;
    end else begin
      if (arm) model_arm();
      else if (rd_req && q.size() > 0) begin
        m_rd = q.pop_front();
        m_rv = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    arm = 0; stop = 0; mode_all = 0; wrap_en = 0; wb_we = 0; stall = 0;
    halt = 0; rd_req = 0; wb_rd = '0; wb_data = '0; pc = '0;
  endtask

  task automatic rand_tap();
    wb_rd = RIDX_W'($urandom); wb_data = DATA_W'($urandom);
    pc = PC_W'($urandom); stall = 1'($urandom);
  endtask

  task automatic start(input bit m, input bit w);
    arm = 1; mode_all = m; wrap_en = w;
    tick();
    arm = 0; mode_all = $urandom % 2; wrap_en = $urandom % 2;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    #2 reset = 1;
    tick(); tick();
    reset = 0;
    n_vec++;
    if ({state, count, overflow, stop_cause, rd_valid} !== '0) begin
      n_err++;
      $display("FAIL reset_status: got state=%b count=%0d ovf=%b cause=%b rv=%b, want all 0",
               state, count, overflow, stop_cause, rd_valid);
    end
    n_vec++;
    if ({rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} !== '0) begin
      n_err++;
      $display("FAIL reset_fields: got %h, want 0", {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall});
    end
  endtask

  task automatic test_basic_halt();
    int exp_ts[3] = '{2, 5, 6};
    start(0, 0);
    n_vec++;
    if (state !== 2'b01) begin n_err++; $display("FAIL basic_arm_state: got %b want 01", state); end
    for (int c = 0; c < 10; c++) begin
      rand_tap();
      wb_we = (c == 2 || c == 5 || c == 6);
      if (c == 2) begin wb_rd = 3'd1; wb_data = 16'h0005; end
      if (c == 5) begin wb_rd = 3'd2; wb_data = 16'h000A; end
      if (c == 6) begin wb_rd = 3'd3; wb_data = 16'h000F; end
      halt = (c == 9);
      tick();
    end
    wb_we = 0; halt = 0;
    n_vec++;
    if ({state, stop_cause, count} !== {2'b10, 2'b01, CW'(3)}) begin
      n_err++;
      $display("FAIL basic_done: got state=%b cause=%b count=%0d want 10/01/3", state, stop_cause, count);
    end
    rd_req = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (rd_valid !== (k < 3)) begin
        n_err++; $display("FAIL basic_rv[%0d]: got %b want %b", k, rd_valid, (k < 3));
      end
      if (k < 3) begin
        n_vec++;
        if (rd_cycle !== CYC_W'(exp_ts[k]) || {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} !== m_rd) begin
          n_err++;
          $display("FAIL basic_entry[%0d]: got cyc=%0d reg=%0d data=%h want cyc=%0d entry=%h",
                   k, rd_cycle, rd_reg, rd_data, exp_ts[k], m_rd);
        end
      end
    end
    rd_req = 0;
  endtask

  task automatic test_full_stop();
    start(0, 0);
    for (int i = 0; i < 20; i++) begin
      rand_tap(); wb_we = 1;
      tick();
      n_vec++;
      if (state !== ((i >= 15) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL full_state[%0d]: got %b", i, state);
      end
    end
    wb_we = 0;
    n_vec++;
    if ({stop_cause, count, overflow} !== {2'b11, CW'(16), 1'b0}) begin
      n_err++;
      $display("FAIL full_done: got cause=%b count=%0d ovf=%b want 11/16/0", stop_cause, count, overflow);
    end
    rd_req = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_vec++;
      if (rd_valid !== 1'b1 || rd_cycle !== CYC_W'(k) ||
          {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} !== m_rd) begin
        n_err++;
        $display("FAIL full_entry[%0d]: got rv=%b cyc=%0d want cyc=%0d entry=%h", k, rd_valid, rd_cycle, k, m_rd);
      end
    end
    rd_req = 0;
  endtask

  task automatic test_wrap_stop();
    start(0, 1);
    for (int i = 0; i < 20; i++) begin
      rand_tap(); wb_we = 1;
      tick();
    end
    wb_we = 0; stop = 1;
    tick();
    stop = 0;
    n_vec++;
    if ({state, stop_cause, count, overflow} !== {2'b10, 2'b00, CW'(16), 1'b1}) begin
      n_err++;
      $display("FAIL wrap_done: got state=%b cause=%b count=%0d ovf=%b want 10/00/16/1",
               state, stop_cause, count, overflow);
    end
    rd_req = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_vec++;
      if (rd_valid !== 1'b1 || rd_cycle !== CYC_W'(k + 4) ||
          {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} !== m_rd) begin
        n_err++;
        $display("FAIL wrap_entry[%0d]: got rv=%b cyc=%0d want cyc=%0d", k, rd_valid, rd_cycle, k + 4);
      end
    end
    rd_req = 0;
  endtask

  task automatic test_timeout();
    int n = 0;
    start(1, 1);
    while (state !== 2'b10 && n < 300) begin
      rand_tap(); wb_we = 1'($urandom);
      tick();
      n++;
    end
    wb_we = 0;
    n_vec++;
    if (n != TIMEOUT) begin n_err++; $display("FAIL timeout_len: got %0d cycles want %0d", n, TIMEOUT); end
    n_vec++;
    if ({stop_cause, count, overflow} !== {2'b10, CW'(16), 1'b1}) begin
      n_err++;
      $display("FAIL timeout_done: got cause=%b count=%0d ovf=%b want 10/16/1", stop_cause, count, overflow);
    end
    rd_req = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_vec++;
      if (rd_valid !== 1'b1 || rd_cycle !== CYC_W'(184 + k) ||
          {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} !== m_rd) begin
        n_err++;
        $display("FAIL timeout_entry[%0d]: got rv=%b cyc=%0d stall=%b want cyc=%0d stall=%b",
                 k, rd_valid, rd_cycle, rd_stall, 184 + k, m_rd.stall);
      end
    end
    rd_req = 0;
  endtask

  task automatic test_halt_full_tie();
    start(0, 0);
    for (int i = 0; i < 16; i++) begin
      rand_tap(); wb_we = 1; halt = (i == 15);
      tick();
    end
    wb_we = 0; halt = 0;
    n_vec++;
    if ({state, stop_cause, count} !== {2'b10, 2'b01, CW'(16)}) begin
      n_err++;
      $display("FAIL tie_cause: got state=%b cause=%b count=%0d want 10/01/16", state, stop_cause, count);
    end
  endtask

  task automatic test_reset_mid_run();
    start(0, 0);
    for (int i = 0; i < 5; i++) begin
      rand_tap(); wb_we = 1;
      tick();
    end
    wb_we = 0;
    n_vec++;
    if (count !== CW'(5)) begin n_err++; $display("FAIL midrun_count: got %0d want 5", count); end
    #2 reset = 1;
    model_reset();
    #1;
    n_vec++;
    if ({state, count, overflow, stop_cause, rd_valid, rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: got state=%b count=%0d ovf=%b cause=%b rv=%b fields=%h want 0",
               state, count, overflow, stop_cause, rd_valid, {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall});
    end
    #1 reset = 0;
    start(0, 0);
    rand_tap(); wb_we = 1;
    tick();
    wb_we = 0; halt = 1;
    tick();
    halt = 0; rd_req = 1;
    tick();
    rd_req = 0;
    n_vec++;
    if (rd_valid !== 1'b1 || rd_cycle !== '0 || {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} !== m_rd) begin
      n_err++;
      $display("FAIL midrun_fresh: got rv=%b cyc=%0d want rv=1 cyc=0", rd_valid, rd_cycle);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      if (m_state == 2'b01) begin stop = 1; tick(); stop = 0; end
      start(1'($urandom), 1'($urandom));
      for (int c = 0; c < 90; c++) begin
        rand_tap();
        wb_we  = 1'($urandom);
        halt   = ($urandom % 50) == 0;
        stop   = ($urandom % 50) == 0;
        arm    = (m_state == 2'b01) ? (($urandom % 6) == 0) : (($urandom % 40) == 0);
        rd_req = ($urandom % 4) != 0;
        if (c >= 60 && m_state == 2'b01) stop = 1;
        tick();
        n_vec++;
        if ({state, count, overflow, stop_cause, rd_valid} !==
            {m_state, CW'(q.size()), m_ovf, m_cause, m_rv}) begin
          n_err++;
          $display("FAIL rand_status[%0d.%0d]: got st=%b cnt=%0d ovf=%b cause=%b rv=%b want %b/%0d/%b/%b/%b",
                   r, c, state, count, overflow, stop_cause, rd_valid,
                   m_state, q.size(), m_ovf, m_cause, m_rv);
        end
        n_vec++;
        if ({rd_cycle, rd_pc, rd_reg, rd_data, rd_stall} !== m_rd) begin
          n_err++;
          $display("FAIL rand_fields[%0d.%0d]: got %h want %h", r, c,
                   {rd_cycle, rd_pc, rd_reg, rd_data, rd_stall}, m_rd);
        end
      end
      idle_inputs();
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    test_reset();
    test_basic_halt();
    test_full_stop();
    test_wrap_stop();
    test_timeout();
    test_halt_full_tie();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_trace_buffer.md
# pipeline_trace_buffer

Synthesizable on-chip trace recorder for the 5-stage 16-bit pipeline. It sits beside the datapath and taps the write-back port, PC, stall and halt. It captures timestamped events into a parametrised circular buffer, freezes on halt, timeout, full or external stop, and is drained through a request/valid readout port. It replaces per-cycle simulation printouts as the way the pipeline is observed, and it works in silicon as well as in simulation.

## Interface
- DATA_W, 16, write-back data width
- PC_W, 16, PC width
- RIDX_W, 3, register index width (8 registers)
- DEPTH, 16, buffer entries; power of two, ≥2
- CYC_W, 16, timestamp width
- TIMEOUT, 200, RUN cycles before forced stop; 0 disables the timeout
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- arm  in  1  pulse; in IDLE or DONE, starts a new capture
- stop  in  1  external stop request while in RUN
- mode_all  in  1  sampled at arm: 1 = record every RUN cycle; 0 = record only wb_we cycles
- wrap_en  in  1  sampled at arm: 1 = overwrite oldest entry when full; 0 = stop when full
- wb_we  in  1  write-back RegWrite
- wb_rd  in  RIDX_W  write-back destination register
- wb_data  in  DATA_W  write-back data
- pc  in  PC_W  fetch PC
- stall  in  1  pipeline stall
- halt  in  1  pipeline halt
- rd_req  in  1  pop oldest entry (honoured in DONE only)
- rd_valid  out  1  one-cycle pulse, entry fields valid
- rd_cycle  out  CYC_W  entry timestamp
- rd_pc  out  PC_W  entry PC
- rd_reg  out  RIDX_W  entry register index
- rd_data  out  DATA_W  entry data
- rd_stall  out  1  entry stall bit
- state  out  2  IDLE=00, RUN=01, DONE=10
- count  out  $clog2(DEPTH)+1  valid entries held
- overflow  out  1  at least one entry was lost to wrap
- stop_cause  out  2  00 external stop, 01 halt, 10 timeout, 11 full

## Operation
- States: IDLE → RUN on arm. RUN → DONE on a stop event. DONE → RUN on arm. No other transitions.
- Arm clears: write and read pointers, count, overflow, stop_cause, and the cycle counter. It also latches mode_all and wrap_en. arm in RUN is ignored.
- Cycle counter: 0 on the first RUN cycle, +1 per RUN cycle, saturates at all-ones.
- Capture condition (RUN only): mode_all=1, or wb_we=1. When it holds, the entry {cycle, pc, wb_rd, wb_data, stall} is written at the write pointer. The pointer wraps modulo DEPTH.
- Full with wrap_en=1: the write overwrites the oldest entry, the read pointer advances, count stays DEPTH, overflow is set.
- Full with wrap_en=0: the write that makes count=DEPTH is also a stop event with cause 11.
- Stop events in RUN: halt=1, the timeout edge (cycle counter = TIMEOUT−1), full (above), stop=1.
- On a stop event, that cycle's entry is captured if it qualifies, and state goes to DONE on the same edge.
- Simultaneous stop events set cause by priority: halt > timeout > full > stop.
- Readout (DONE only): rd_req with count>0 → next cycle rd_valid=1 with the oldest entry; count decrements and the read pointer advances. rd_req with count=0 → rd_valid stays 0 and nothing changes.
- arm together with rd_req in DONE: arm wins and no rd_valid is produced.
- Inputs other than arm are ignored in IDLE. rd_req is ignored outside DONE.

## Timing
- Reset (async, any time, including mid-RUN or mid-readout) forces: state=IDLE, count=0, overflow=0, stop_cause=00, rd_valid=0, all rd_* fields 0, pointers and cycle counter 0. Buffer contents are don't-care.
- arm sampled at edge N → state=RUN after edge N. The first capturable cycle is N+1, with timestamp 0.
- Capture: the entry is written at the sampling edge. count, overflow, state and stop_cause are visible after that same edge.
- Read latency is 1 cycle. Back-to-back rd_req on every cycle returns one entry per cycle in age order.
- Simultaneous capture and readout cannot occur, because the two are separated by state.

## Test plan
- Setup: arm with mode_all=0, wrap_en=0. Stimulus: writebacks R1=0005, R2=000A, R3=000F at RUN cycles 2, 5, 6; halt at cycle 9. Required: DONE, cause 01, count 3. Four rd_req → entries with cycles 2, 5, 6 in order, then rd_valid=0.
- Setup: wrap_en=0. Stimulus: 20 consecutive writebacks. Required: DONE after the 16th, cause 11, count 16, overflow 0, timestamps 0..15 read out.
- Setup: wrap_en=1. Stimulus: 20 consecutive writebacks, then stop. Required: cause 00, count 16, overflow 1, readout timestamps 4..19.
- Setup: mode_all=1, wrap_en=1, TIMEOUT=200. Stimulus: no halt. Required: DONE after 200 RUN cycles, cause 10, last entry timestamp 199 (C7), stall bits match the stimulus.
- Stimulus: halt and the 16th write on the same edge with wrap_en=0. Required: cause 01 (halt outranks full).
- Stimulus: reset asserted mid-RUN with count=5. Required: all outputs at reset values immediately. A following arm starts a fresh capture with timestamp 0.
